// File: rtl/handshake_eager_fork.sv
// Registered 1-to-NUM_RX broadcast with per-consumer served mask; a beat retires once every consumer took it.
// Optional per-consumer stall counters enabled by HANDSHAKE_EAGER_FORK_STALL_CNT_EN.
module handshake_eager_fork #(
  parameter int NUM_RX          = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int STALL_CNT_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [NUM_RX-1:0]     rx_valid,
  input  logic [NUM_RX-1:0]     rx_ready
`ifdef HANDSHAKE_EAGER_FORK_STALL_CNT_EN
  ,
  output logic [NUM_RX*STALL_CNT_WIDTH-1:0] stall_cnt
`endif
);

  if (NUM_RX < 1 || DATA_WIDTH < 1 || STALL_CNT_WIDTH < 1) begin : g_param_err
    $error("handshake_eager_fork: parameters must be >= 1");
  end

  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [NUM_RX-1:0]     served;
  logic [NUM_RX-1:0]     fire;
  logic                  all_done;

  always_comb begin
    rx_valid = {NUM_RX{buf_valid & rst_ni}} & ~served;
    rx_data  = buf_data;
    fire     = rx_valid & rx_ready;
    all_done = buf_valid & (&(served | fire));
    // rx_ready feeds tx_ready combinationally so a retiring beat can be replaced in the same cycle
    tx_ready = rst_ni & (~buf_valid | all_done);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
      served    <= '0;
    end else if (!buf_valid || all_done) begin
      buf_valid <= tx_valid;
      if (tx_valid) buf_data <= tx_data;
      served    <= '0;
    end else begin
      served <= served | fire;
    end
  end

`ifdef HANDSHAKE_EAGER_FORK_STALL_CNT_EN
  for (genvar i = 0; i < NUM_RX; i++) begin : g_stall
    logic [STALL_CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cnt <= '0;
      end else if (fire[i]) begin
        cnt <= '0;
      end else if (rx_valid[i] && !rx_ready[i] && (cnt != {STALL_CNT_WIDTH{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stall_cnt[i*STALL_CNT_WIDTH +: STALL_CNT_WIDTH] = cnt;
  end
`endif

endmodule

// File: tb/tb_handshake_eager_fork.sv
// Randomized plus directed bench for handshake_eager_fork against a beat-count reference model.
module tb_handshake_eager_fork;
  localparam int NRX = 2;
  localparam int DW  = 8;
  localparam int SCW = 2;

  logic           clk_i;
  logic           rst_ni;
  logic [DW-1:0]  tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [DW-1:0]  rx_data;
  logic [NRX-1:0] rx_valid;
  logic [NRX-1:0] rx_ready;
`ifdef HANDSHAKE_EAGER_FORK_STALL_CNT_EN
  logic [NRX*SCW-1:0] stall_cnt;
`endif

  handshake_eager_fork #(.NUM_RX(NRX), .DATA_WIDTH(DW), .STALL_CNT_WIDTH(SCW)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
`ifdef HANDSHAKE_EAGER_FORK_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int total = 0;
  int bad   = 0;

  // Model: accepted beats are numbered; each consumer tracks how many it has taken.
  logic [DW-1:0] beats [0:8191];
  int            n_acc = 0;
  int            n_got [NRX];
  int            stall_m [NRX];
  logic          last_acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic tv, input logic [DW-1:0] td, input logic [NRX-1:0] rr);
    logic [NRX-1:0] exp_rv;
    logic           exp_tr;
    rst_ni   = rst;
    tx_valid = tv;
    tx_data  = td;
    rx_ready = rr;
    @(negedge clk_i);
    exp_tr = rst;
    for (int i = 0; i < NRX; i++) begin
      exp_rv[i] = rst && (n_got[i] < n_acc);
      if (n_got[i] + ((exp_rv[i] && rr[i]) ? 1 : 0) < n_acc) exp_tr = 1'b0;
    end
    check_val("tx_ready", {31'd0, tx_ready}, {31'd0, exp_tr});
    check_val("rx_valid", {30'd0, rx_valid}, {30'd0, exp_rv});
    if (exp_rv != '0) check_val("rx_data", {24'd0, rx_data}, {24'd0, beats[n_acc-1]});
`ifdef HANDSHAKE_EAGER_FORK_STALL_CNT_EN
    for (int i = 0; i < NRX; i++)
      check_val($sformatf("stall_cnt%0d", i), {30'd0, stall_cnt[i*SCW +: SCW]}, stall_m[i]);
`endif
    @(posedge clk_i);
    #1;
    last_acc = rst && tv && exp_tr;
    if (!rst) begin
      for (int i = 0; i < NRX; i++) begin
        n_got[i]   = n_acc;
        stall_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < NRX; i++) begin
        if (exp_rv[i] && rr[i]) begin
          n_got[i]++;
          stall_m[i] = 0;
        end else if (exp_rv[i] && !rr[i] && stall_m[i] < (1 << SCW) - 1) begin
          stall_m[i]++;
        end
      end
      if (last_acc) begin
        beats[n_acc] = td;
        n_acc++;
      end
    end
  endtask

  initial begin
    logic          tv;
    logic [DW-1:0] td;
    for (int i = 0; i < NRX; i++) begin
      n_got[i]   = 0;
      stall_m[i] = 0;
    end
    last_acc = 1'b0;

    // reset held with a pending producer
    step(1'b0, 1'b1, 8'h77, 2'b00);
    step(1'b0, 1'b1, 8'h77, 2'b00);
    step(1'b1, 1'b0, 8'h00, 2'b11);
    check_val("rst_data", {24'd0, rx_data}, 32'd0);

    // back-to-back stream
    step(1'b1, 1'b1, 8'h11, 2'b11);
    step(1'b1, 1'b1, 8'h22, 2'b11);
    step(1'b1, 1'b1, 8'h33, 2'b11);
    step(1'b1, 1'b0, 8'h00, 2'b11);
    step(1'b1, 1'b0, 8'h00, 2'b11);

    // eager consumer, then retire with a new beat in the same cycle
    step(1'b1, 1'b1, 8'hA5, 2'b00);
    step(1'b1, 1'b0, 8'h00, 2'b01);
    step(1'b1, 1'b0, 8'h00, 2'b01);
    step(1'b1, 1'b1, 8'h5A, 2'b10);
    step(1'b1, 1'b0, 8'h00, 2'b00);
    check_val("b2b_data", {24'd0, rx_data}, 32'h5A);

    // partial beat discarded by reset
    step(1'b1, 1'b0, 8'h00, 2'b01);
    step(1'b0, 1'b0, 8'h00, 2'b00);
    step(1'b1, 1'b0, 8'h00, 2'b11);
    step(1'b1, 1'b0, 8'h00, 2'b11);

    // long stall on consumer 1
    step(1'b1, 1'b1, 8'hC3, 2'b00);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'h00, 2'b01);
    step(1'b1, 1'b0, 8'h00, 2'b10);
    step(1'b1, 1'b0, 8'h00, 2'b00);

    // random traffic; producer holds its beat until accepted
    tv = 1'b0;
    td = '0;
    last_acc = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (!(tv && !last_acc)) begin
        tv = ($urandom_range(0, 3) != 0);
        td = DW'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        step(1'b0, tv, td, NRX'($urandom));
        tv = 1'b0;
      end else begin
        step(1'b1, tv, td, NRX'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
